// File: rtl/regfile_pkg.sv
// Shared register-file constants and index type for the write-back path.
package regfile_pkg;

    localparam int unsigned NUM_GPR = 32;
    localparam int unsigned GPR_AW  = 5;

    typedef logic [GPR_AW-1:0] gpr_idx_t;

    localparam gpr_idx_t ZERO_REG = gpr_idx_t'(0);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req, search starts after the last winner.
// The pointer resets to N-1 so that index 0 wins first after reset.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         aclr_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic [PW-1:0] win_idx;
    logic          found;

    // Grant search from ptr+1 wrapping around; no grant while reset is held.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        idx     = '0;
        win_idx = '0;
        if (aclr_n) begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx = PW'((32'(ptr_q) + k) % N);
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    win_idx  = idx;
                    gnt[idx] = 1'b1;
                end
            end
        end
        ptr_d = found ? win_idx : ptr_q;
    end

    // Pointer register: follows the winner of each transfer.
    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with per-register pending scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN adds forwarding of the data held in the
// write-back register to the two decode read ports.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32,
    parameter int unsigned RF_AW = 8
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_addr,
    input  logic [AW-1:0]        rd_addr_a,
    input  logic [AW-1:0]        rd_addr_b,
    output logic                 busy_a,
    output logic                 busy_b,
    output logic [NUM_GPR-1:0]   pending,
    output logic                 rf_wren,
    output logic [RF_AW-1:0]     rf_addr_w,
    output logic [DW-1:0]        rf_data_w
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [DW-1:0]        rf_data_a,
    input  logic [DW-1:0]        rf_data_b,
    output logic [DW-1:0]        fwd_data_a,
    output logic [DW-1:0]        fwd_data_b
`endif
);

    logic [NREQ-1:0]    gnt;
    logic               xfer;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_data;

    logic               rf_wren_q,   rf_wren_d;
    logic [RF_AW-1:0]   rf_addr_w_q, rf_addr_w_d;
    logic [DW-1:0]      rf_data_w_q, rf_data_w_d;
    logic [NUM_GPR-1:0] pending_q,   pending_d;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk    (clk),
        .aclr_n (aclr_n),
        .req    (req_valid),
        .gnt    (gnt)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Write-back register next state; writes to x0 are accepted but not enabled.
    always_comb begin
        rf_wren_d   = 1'b0;
        rf_addr_w_d = rf_addr_w_q;
        rf_data_w_d = rf_data_w_q;
        if (xfer) begin
            rf_wren_d   = (gpr_idx_t'(sel_addr) != ZERO_REG);
            rf_addr_w_d = RF_AW'(sel_addr);
            rf_data_w_d = sel_data;
        end
    end

    // Scoreboard next state: clear on commit, then set on issue so a new producer wins.
    always_comb begin
        pending_d = pending_q;
        if (rf_wren_q) begin
            pending_d[gpr_idx_t'(rf_addr_w_q)] = 1'b0;
        end
        if (iss_valid) begin
            pending_d[gpr_idx_t'(iss_addr)] = 1'b1;
        end
        pending_d[ZERO_REG] = 1'b0;
    end

    // State registers for write-back and scoreboard.
    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            rf_wren_q   <= 1'b0;
            rf_addr_w_q <= '0;
            rf_data_w_q <= '0;
            pending_q   <= '0;
        end else begin
            rf_wren_q   <= rf_wren_d;
            rf_addr_w_q <= rf_addr_w_d;
            rf_data_w_q <= rf_data_w_d;
            pending_q   <= pending_d;
        end
    end

    assign rf_wren   = rf_wren_q;
    assign rf_addr_w = rf_addr_w_q;
    assign rf_data_w = rf_data_w_q;
    assign pending   = pending_q;

`ifdef REGFILE_WB_BYPASS_EN
    logic hit_a;
    logic hit_b;

    // Busy/forward: data sitting in the write-back register is served directly.
    always_comb begin
        hit_a = rf_wren_q && (rf_addr_w_q == RF_AW'(rd_addr_a))
                && (gpr_idx_t'(rd_addr_a) != ZERO_REG);
        hit_b = rf_wren_q && (rf_addr_w_q == RF_AW'(rd_addr_b))
                && (gpr_idx_t'(rd_addr_b) != ZERO_REG);
        busy_a     = pending_q[gpr_idx_t'(rd_addr_a)] && !hit_a;
        busy_b     = pending_q[gpr_idx_t'(rd_addr_b)] && !hit_b;
        fwd_data_a = hit_a ? rf_data_w_q : rf_data_a;
        fwd_data_b = hit_b ? rf_data_w_q : rf_data_b;
    end
`else
    // Busy: straight lookup of the scoreboard.
    always_comb begin
        busy_a = pending_q[gpr_idx_t'(rd_addr_a)];
        busy_b = pending_q[gpr_idx_t'(rd_addr_b)];
    end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 general-purpose register file among NREQ write-back requesters, e.g. ALU, load unit and mul/div unit.
- Keeps a per-register pending scoreboard so that issue logic can stall reads of registers with outstanding writes.
- Sits between the execute/memory units and the register file. It owns the register file's wren/addr_w/data_w and observes its read addresses.

Parameters:
- NREQ, 3, number of write-back requesters (2..8).
- AW, 5, architectural register index width.
- DW, 32, data width.
- RF_AW, 8, register-file address port width; upper bits are driven zero.

Ports:
- clk  in  1  system clock, rising edge.
- aclr_n  in  1  reset, synchronous, active-low. Sampled only on the clk rising edge.
- req_valid  in  NREQ  requester i has a write-back pending.
- req_ready  out  NREQ  one-hot grant; transfer happens when req_valid[i] and req_ready[i] are both high.
- req_addr  in  NREQ*AW  packed destination register indices, requester i at [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_addr  in  AW  destination register of the issuing instruction.
- rd_addr_a, rd_addr_b  in  AW each  source registers of the instruction in decode.
- busy_a, busy_b  out  1 each  the source register has an outstanding write; decode must stall.
- pending  out  32  scoreboard vector, bit r = register r pending.
- rf_wren  out  1  to regfile wren.
- rf_addr_w  out  RF_AW  to regfile addr_w.
- rf_data_w  out  DW  to regfile data_w.

Behaviour:
- Reset (aclr_n low at a rising edge):
  - rf_wren=0, rf_addr_w=0, rf_data_w=0, pending=0.
  - Round-robin pointer = NREQ-1, so requester 0 has top priority first.
  - Reset takes priority over every simultaneous event. In-flight write-backs are dropped; requesters must re-present them.
- Arbitration:
  - Combinational round-robin over req_valid. Search starts at (ptr+1) mod NREQ.
  - At most one req_ready bit is high, and only for a valid requester.
  - ptr updates to the granted index on a transfer and holds otherwise.
- Write-back register (WB):
  - On a transfer, WB loads rf_wren=1, rf_addr_w={0,req_addr}, rf_data_w=req_data on the same edge.
  - With no transfer, WB loads rf_wren=0; addr and data hold.
  - The register file commits at the following edge. Latency from handshake to register-file update is 1 cycle.
  - No back-pressure: the register file always accepts, so the grant logic never stalls.
- Register x0:
  - A transfer with req_addr=0 is accepted (ready asserted) but loads rf_wren=0.
  - iss_valid with iss_addr=0 never sets pending[0]. pending[0] is constantly 0.
- Scoreboard, per register r, at each rising edge:
  - Set when iss_valid and iss_addr==r.
  - Clear when rf_wren and rf_addr_w==r, i.e. the edge at which the register file commits.
  - Set and clear on the same r in the same edge: set wins, because the newer producer is outstanding.
- Busy outputs:
  - busy_a = pending[rd_addr_a]; busy_b likewise. Purely combinational from the pending state.
  - A register whose data sits in WB still reads busy (without the optional feature).
- Two requesters targeting the same register in consecutive cycles are written in grant order; last write wins. Ordering across units is the issue logic's responsibility.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- When defined:
  - Adds inputs rf_data_a, rf_data_b (DW each, from regfile data_a/data_b) and outputs fwd_data_a, fwd_data_b (DW each).
  - fwd_data_x = rf_data_w when rf_wren and rf_addr_w==rd_addr_x (nonzero); otherwise fwd_data_x = rf_data_x.
  - busy_x is additionally deasserted in that same match case.
- When undefined: none of these ports exist, and busy_x behaves as stated above.

Decomposition:
- Shared package regfile_pkg holds:
  - Constants NUM_GPR=32 and GPR_AW=5.
  - Register-index typedef gpr_idx_t.
  - Constant ZERO_REG=0.
- One sub-module, rr_arbiter (parameter N), holds the pointer and produces the one-hot grant. The arbiter's ptr state lives inside it.
- Scoreboard and WB register stay in the top level.

Test Plan:
- Reset: hold aclr_n=0 two cycles with all req_valid=1 → rf_wren=0, pending=0, req_ready=0 while in reset. After release, the first grant goes to requester 0.
- Round-robin: req_valid=3'b111 held for 6 cycles, addrs 1/2/3 → grants 0,1,2,0,1,2. rf_wren=1 each cycle, one cycle behind each grant, with the matching addr/data.
- Scoreboard lifecycle: iss r5 at cycle 0 → pending[5]=1 and busy_a=1 for rd_addr_a=5. Requester 1 writes r5 = 0xDEADBEEF at cycle 3 → rf_wren with addr 5 at cycle 4. pending[5]=0 from cycle 5.
- Set/clear collision: WB writing r7 while iss_valid with iss_addr=7 in the same cycle → pending[7] remains 1 afterwards.
- x0 handling: req to r0 with data 0x1234, plus iss r0 → req_ready asserted, rf_wren stays 0, pending[0]=0.
- Bypass (REGFILE_WB_BYPASS_EN): WB holds r9 = 0xCAFEF00D, rd_addr_a=9, rf_data_a=0 → fwd_data_a=0xCAFEF00D and busy_a=0. Without the macro → busy_a=1.
